instr_mem_fetch: RTL
====================

// Module: instr_mem_fetch
// PURPOSE
//  Parametrised instruction memory with a registered fetch port and a run-time programming port.
//  Sits between the PC register and the decoder. Instructions can be loaded over the programming
//  port instead of a hard-coded initial block. Fetches use a valid/ready handshake so the decoder
//  can stall. An optional post-reset clear pass fills the whole array with NOP.
// PARAMETERS
//  IW          16        instruction width in bits
//  AW          10        address (PC) width in bits
//  DEPTH       1024      number of words; must be <= 2**AW
//  NOP         16'h0000  word written by the clear pass and returned for out-of-range fetches
//  CLEAR_INIT  1         1: run the clear pass after every reset; 0: go straight to RUN
// PORTS
//  clk         in   1   system clock; all state changes on rising edge
//  rst         in   1   asynchronous, active-high reset
//  fetch_req   in   1   request a fetch at fetch_pc
//  fetch_pc    in   AW  word address to fetch
//  fetch_ready out  1   fetch accepted this cycle when fetch_req && fetch_ready
//  ins_out     out  IW  fetched instruction; held stable while ins_valid && !ins_ready
//  ins_valid   out  1   ins_out holds an undelivered instruction
//  ins_ready   in   1   consumer takes ins_out when ins_valid && ins_ready
//  prog_we     in   1   write prog_data to prog_addr; honoured only when prog_ready
//  prog_addr   in   AW  programming word address
//  prog_data   in   IW  programming data
//  prog_ready  out  1   0 during the clear pass, 1 otherwise
//  addr_err    out  1   sticky flag: an out-of-range fetch or program address was seen
// BEHAVIOUR
//  Reset values (immediate, asynchronous):
//   ins_out=NOP, ins_valid=0, addr_err=0, clear counter=0.
//   State=CLEAR if CLEAR_INIT, else RUN. Array contents are not reset.
//  FSM states: CLEAR, RUN.
//   CLEAR: writes NOP to word clr_cnt each cycle, clr_cnt 0..DEPTH-1.
//     fetch_ready=0 and prog_ready=0 throughout; prog_we is ignored.
//     Goes to RUN after the write of DEPTH-1, so the pass takes exactly DEPTH cycles.
//   RUN: fetch_ready = !ins_valid || ins_ready (one-entry output skid); prog_ready=1.
//  Fetch latency: accepted at edge N -> ins_out/ins_valid updated at edge N+1 (1 cycle).
//   Back-to-back fetches sustain 1 per cycle while ins_ready=1.
//  ins_valid next-state:
//   - set on an accepted fetch;
//   - else cleared when ins_ready;
//   - else held.
//  Stall: while ins_valid && !ins_ready, ins_out and ins_valid hold and no fetch is accepted.
//  Range rule: an address >= DEPTH is out of range.
//   - Out-of-range fetch completes normally with ins_out=NOP and sets addr_err.
//   - Out-of-range prog_we is dropped and sets addr_err.
//   - addr_err clears only on rst.
//  Same-cycle write and fetch to the same address: write-first, so the fetch returns prog_data.
//   A write to a different address does not disturb the fetch.
//  Reset during CLEAR restarts the pass at word 0. Reset with ins_valid=1 discards that instruction.
//  Width rules: addresses are compared zero-extended. No arithmetic on data. clr_cnt is AW+1 bits.
// STRUCTURE
//  Shared package (imem_pkg): IW/AW defaults, NOP encoding, and state enum {CLEAR, RUN}.
//  One sub-module: imem_ram_1w1r. Plain DEPTH x IW array with one synchronous write port and one
//   synchronous read port, no reset. The write-first bypass lives in the top-level.
//  Top-level holds the FSM, clear counter, range check, skid/valid logic and error flag.
//  The write port mux selects between the clear pass and the programming port.
// TESTING
//  1 Reset, CLEAR_INIT=1, DEPTH=1024:
//     prog_ready=0 and fetch_ready=0 for exactly 1024 cycles, then both 1.
//     A fetch of pc=5 then returns 16'h0000.
//  2 Program addr 0..3 = 16'h8080, 16'h8504, 16'h080A, 16'h8602, then fetch 0..3 back-to-back
//     with ins_ready=1: ins_out matches, one per cycle, ins_valid continuous.
//  3 Fetch pc=2 with ins_ready=0 for 3 cycles:
//     ins_out=16'h080A held and fetch_ready=0 throughout.
//     Raise ins_ready: pending fetch of pc=3 returns 16'h8602 next cycle.
//  4 Same cycle: prog_we with addr=7, data=16'h1814, plus fetch pc=7.
//     Next cycle ins_out=16'h1814. The old word is never observed.
//  5 DEPTH=1000: fetch pc=1010 returns NOP and sets addr_err=1.
//     prog_we at 1020 leaves the array unchanged.
//     addr_err stays 1 until rst.
//  6 Assert rst mid-CLEAR at clr_cnt=300 and with ins_valid=1:
//     outputs return to reset values at once, and the pass restarts from word 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch block.
//   IMEM_IW / IMEM_AW : default instruction and address widths
//   IMEM_NOP          : default NOP encoding
//   imem_state_e      : controller state (clear pass or normal run)
//   imem_src_e        : which source drives the fetched instruction
//   addr_in_range     : zero-extended range test against the array depth
package imem_pkg;

    localparam int unsigned IMEM_IW  = 16;
    localparam int unsigned IMEM_AW  = 10;
    localparam logic [15:0] IMEM_NOP = 16'h0000;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,
        SRC_RAM = 2'd1,
        SRC_BYP = 2'd2
    } imem_src_e;

    // Addresses are zero-extended to 32 bits before comparing with the depth.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/imem_ram_1w1r.sv
// Plain DEPTH x IW storage array, one synchronous write port, one synchronous
// read port, no reset. Read-during-write to the same word returns the old word;
// the caller is responsible for any bypass.
//   clk            : clock
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr   : read enable and address
//   o_rdata        : registered read data, holds while i_re is low
module imem_ram_1w1r #(
    parameter int unsigned IW    = 16,
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 1024
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_rdata;

    // Storage write and registered read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a registered valid/ready fetch port, a run-time
// programming port and an optional post-reset NOP clear pass.
//   clk, rst                 : clock, asynchronous active-high reset
//   fetch_req/fetch_pc       : fetch request and word address
//   fetch_ready              : fetch accepted when fetch_req && fetch_ready
//   ins_out/ins_valid        : fetched instruction and its valid flag
//   ins_ready                : consumer takes ins_out when ins_valid && ins_ready
//   prog_we/prog_addr/prog_data : programming write port
//   prog_ready               : low during the clear pass
//   addr_err                 : sticky out-of-range fetch/program flag
module instr_mem_fetch
    import imem_pkg::*;
#(
    parameter int unsigned   IW         = IMEM_IW,
    parameter int unsigned   AW         = IMEM_AW,
    parameter int unsigned   DEPTH      = 1024,
    parameter logic [IW-1:0] NOP        = IW'(IMEM_NOP),
    parameter bit            CLEAR_INIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_pc,
    output logic          fetch_ready,
    output logic [IW-1:0] ins_out,
    output logic          ins_valid,
    input  logic          ins_ready,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic          prog_ready,
    output logic          addr_err
);

    localparam int unsigned    CW        = AW + 1;
    localparam logic [CW-1:0]  CLR_LAST  = CW'(DEPTH - 1);

    imem_state_e   r_state;
    logic [CW-1:0] r_clr_cnt;
    logic          r_ins_valid;
    logic          r_addr_err;
    imem_src_e     r_src;
    logic [IW-1:0] r_byp_data;

    logic          w_run;
    logic          w_fetch_ok;
    logic          w_prog_ok;
    logic          w_accept;
    logic          w_prog_wr;
    logic          w_hit;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_waddr;
    logic [IW-1:0] w_ram_wdata;
    logic          w_ram_re;
    logic [IW-1:0] w_ram_rdata;

    assign w_run      = (r_state == ST_RUN);
    assign w_fetch_ok = addr_in_range(32'(fetch_pc), DEPTH);
    assign w_prog_ok  = addr_in_range(32'(prog_addr), DEPTH);

    // One-entry skid: a new fetch is taken only if the output slot frees this cycle.
    assign fetch_ready = w_run && (!r_ins_valid || ins_ready);
    assign prog_ready  = w_run;
    assign w_accept    = fetch_req && fetch_ready;
    assign w_prog_wr   = w_run && prog_we && w_prog_ok;

    // Same-word write and fetch: take the write data instead of the stale array word.
    assign w_hit = w_prog_wr && (prog_addr == fetch_pc);

    // Write port mux: clear pass owns the port until the array is filled.
    assign w_ram_we    = !w_run || w_prog_wr;
    assign w_ram_waddr = w_run ? prog_addr : r_clr_cnt[AW-1:0];
    assign w_ram_wdata = w_run ? prog_data : NOP;
    assign w_ram_re    = w_accept && w_fetch_ok && !w_hit;

    imem_ram_1w1r #(
        .IW    (IW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (fetch_pc),
        .o_rdata (w_ram_rdata)
    );

    // Controller, clear counter, output slot and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CLEAR_INIT ? ST_CLEAR : ST_RUN;
            r_clr_cnt   <= '0;
            r_ins_valid <= 1'b0;
            r_addr_err  <= 1'b0;
            r_src       <= SRC_NOP;
            r_byp_data  <= NOP;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + CW'(1);
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (w_accept) begin
                r_ins_valid <= 1'b1;
                if (!w_fetch_ok) begin
                    r_src <= SRC_NOP;
                end else if (w_hit) begin
                    r_src      <= SRC_BYP;
                    r_byp_data <= prog_data;
                end else begin
                    r_src <= SRC_RAM;
                end
            end else if (ins_ready) begin
                r_ins_valid <= 1'b0;
            end

            if ((w_accept && !w_fetch_ok) || (w_run && prog_we && !w_prog_ok)) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // Output select; every source is a register, so ins_out holds during a stall.
    always_comb begin
        ins_out = NOP;
        case (r_src)
            SRC_RAM: ins_out = w_ram_rdata;
            SRC_BYP: ins_out = r_byp_data;
            default: ins_out = NOP;
        endcase
    end

    assign ins_valid = r_ins_valid;
    assign addr_err  = r_addr_err;

endmodule
